// File: rtl/mprj_io_cfg_loader.sv
// Serial configuration loader for user I/O pad control cells: holds a per-pad
// config register file and shifts it out MSB-first over NUM_CHAINS parallel chains.
module mprj_io_cfg_loader #(
    parameter int                  NUM_PADS    = 38,
    parameter int                  NUM_CHAINS  = 2,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cfg_wr,
    input  logic [$clog2(NUM_PADS)-1:0]  cfg_addr,
    input  logic [CFG_BITS-1:0]          cfg_wdata,
    output logic [CFG_BITS-1:0]          cfg_rdata,
    output logic                         cfg_wr_err,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         loader_resetn,
    output logic                         loader_clock,
    output logic                         loader_load,
    output logic [NUM_CHAINS-1:0]        loader_data
);
    localparam int AW    = $clog2(NUM_PADS);
    localparam int PPC   = (NUM_PADS + NUM_CHAINS - 1) / NUM_CHAINS;
    localparam int NBITS = PPC * CFG_BITS;
    localparam int TOT   = PPC * NUM_CHAINS;
    localparam int BCW   = $clog2(NBITS + 1);
    localparam int DW    = $clog2(2 * CLK_DIV);
    localparam int SW    = (PPC > 1) ? $clog2(PPC) : 1;
    localparam int PBW   = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PW    = (TOT > 1) ? $clog2(TOT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CRST, S_SHIFT, S_LOAD, S_DONE} state_t;

    state_t                             r_state, w_state_nxt;
    logic [DW-1:0]                      r_div;
    logic [BCW-1:0]                     r_bit;
    logic [SW-1:0]                      r_slot;
    logic [PBW-1:0]                     r_pbit;
    logic                               r_wr_err;
    logic [NUM_PADS-1:0][CFG_BITS-1:0]  r_cfg;

    logic                               w_div_last, w_bit_last, w_load_last;
    logic                               w_in_range, w_wr_ok;
    logic [CFG_BITS-1:0]                w_rtbl [2**AW];
    logic [CFG_BITS-1:0]                w_stbl [2**PW];
    logic [NUM_CHAINS-1:0][PW-1:0]      w_idx;
    logic [NUM_CHAINS-1:0]              w_bits;

    assign w_in_range = {1'b0, cfg_addr} < (AW+1)'(NUM_PADS);
    assign w_wr_ok    = cfg_wr && (r_state == S_IDLE) && w_in_range;

    // Zero-padded views of the register file: out-of-range reads and
    // non-existent padding slots both resolve to 0 without extra compare logic.
    for (genvar i = 0; i < 2**AW; i++) begin : g_rtbl
        if (i < NUM_PADS) begin : g_pad
            assign w_rtbl[i] = r_cfg[i];
        end else begin : g_nopad
            assign w_rtbl[i] = '0;
        end
    end

    for (genvar i = 0; i < 2**PW; i++) begin : g_stbl
        if (i < NUM_PADS) begin : g_pad
            assign w_stbl[i] = r_cfg[i];
        end else begin : g_nopad
            assign w_stbl[i] = '0;
        end
    end

    // Slot 0 of chain c carries the highest pad of that chain's group.
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        localparam int BASE = c * PPC + PPC - 1;
        assign w_idx[c]  = PW'(BASE) - PW'(r_slot);
        assign w_bits[c] = w_stbl[w_idx[c]][r_pbit];
    end

    assign cfg_rdata  = w_rtbl[cfg_addr];
    assign cfg_wr_err = r_wr_err;

    assign w_div_last  = (r_div == DW'(2 * CLK_DIV - 1));
    assign w_load_last = (r_div == DW'(CLK_DIV - 1));
    assign w_bit_last  = (r_bit == BCW'(NBITS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CRST;
            S_CRST:  if (w_div_last) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_div_last && w_bit_last) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_load_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        loader_resetn = (r_state != S_CRST);
        loader_clock  = (r_state == S_SHIFT) && (r_div >= DW'(CLK_DIV));
        loader_load   = (r_state == S_LOAD);
        loader_data   = '0;
        if (r_state == S_SHIFT) loader_data = w_bits;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_slot   <= '0;
            r_pbit   <= PBW'(CFG_BITS - 1);
            r_wr_err <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) r_cfg[i] <= DEFAULT_CFG;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_err <= cfg_wr && !w_wr_ok;
            if (w_wr_ok) r_cfg[cfg_addr] <= cfg_wdata;
            if (w_state_nxt != r_state) begin
                r_div  <= '0;
                r_bit  <= '0;
                r_slot <= '0;
                r_pbit <= PBW'(CFG_BITS - 1);
            end else if (r_state != S_IDLE) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;
                if (r_state == S_SHIFT && w_div_last) begin
                    r_bit <= r_bit + 1'b1;
                    if (r_pbit == '0) begin
                        r_pbit <= PBW'(CFG_BITS - 1);
                        r_slot <= r_slot + 1'b1;
                    end else begin
                        r_pbit <= r_pbit - 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Directed bench for mprj_io_cfg_loader: default 38-pad instance plus a small
// 5-pad/4-bit instance for the odd-padding stream.
module tb_mprj_io_cfg_loader;
    logic        clk, resetn;
    logic        cfg_wr, start;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_wdata, cfg_rdata;
    logic        cfg_wr_err, busy, done, loader_resetn, loader_clock, loader_load;
    logic [1:0]  loader_data;

    logic        b_cfg_wr, b_start;
    logic [2:0]  b_cfg_addr;
    logic [3:0]  b_cfg_wdata, b_cfg_rdata;
    logic        b_cfg_wr_err, b_busy, b_done, b_loader_resetn, b_loader_clock, b_loader_load;
    logic [1:0]  b_loader_data;

    int n_cmp = 0, n_bad = 0;

    // Per-run observations
    int rst_first, rst_last, rst_cnt, nrise, load_first, load_last, load_cnt;
    int done_cyc, done_cnt, busy_low, busy_after, err_cnt, err_first;
    logic [7:0] snap;
    logic cap0 [256];
    logic cap1 [256];

    mprj_io_cfg_loader dut (
        .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_wr_err(cfg_wr_err),
        .start(start), .busy(busy), .done(done), .loader_resetn(loader_resetn),
        .loader_clock(loader_clock), .loader_load(loader_load), .loader_data(loader_data)
    );

    mprj_io_cfg_loader #(
        .NUM_PADS(5), .NUM_CHAINS(2), .CFG_BITS(4), .CLK_DIV(1), .DEFAULT_CFG(4'h3)
    ) dut2 (
        .clk(clk), .resetn(resetn), .cfg_wr(b_cfg_wr), .cfg_addr(b_cfg_addr),
        .cfg_wdata(b_cfg_wdata), .cfg_rdata(b_cfg_rdata), .cfg_wr_err(b_cfg_wr_err),
        .start(b_start), .busy(b_busy), .done(b_done), .loader_resetn(b_loader_resetn),
        .loader_clock(b_loader_clock), .loader_load(b_loader_load), .loader_data(b_loader_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [5:0] a, input logic [12:0] d, output logic err);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        err = cfg_wr_err;
        cfg_wr = 1'b0;
    endtask

    // Cycle n = the cycle after the n-th edge following the start-sample edge (edge 0).
    task automatic run_seq(input int wr_cyc, input int st2_cyc, input int st3_cyc, input int rst_cyc);
        logic pclk;
        rst_first = -1; rst_last = -1; rst_cnt = 0; nrise = 0;
        load_first = -1; load_last = -1; load_cnt = 0;
        done_cyc = -1; done_cnt = 0; busy_low = -1; busy_after = 0;
        err_cnt = 0; err_first = -1; snap = 8'hFF;
        @(negedge clk);
        start = 1'b1; cfg_wr = 1'b0;
        pclk = 1'b0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(negedge clk);
            if (!loader_resetn) begin
                rst_cnt++; if (rst_first < 0) rst_first = cyc; rst_last = cyc;
            end
            if (loader_clock && !pclk) begin
                if (nrise < 256) begin cap0[nrise] = loader_data[0]; cap1[nrise] = loader_data[1]; end
                nrise++;
            end
            pclk = loader_clock;
            if (loader_load) begin
                load_cnt++; if (load_first < 0) load_first = cyc; load_last = cyc;
            end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (!busy && busy_low < 0) busy_low = cyc;
            if (busy && busy_low >= 0) busy_after++;
            if (cfg_wr_err) begin err_cnt++; if (err_first < 0) err_first = cyc; end
            if (cyc == rst_cyc + 1)
                snap = {busy, done, cfg_wr_err, loader_resetn, loader_clock, loader_load, loader_data};
            start = (cyc == st2_cyc) || (cyc == st3_cyc);
            cfg_wr = (cyc == wr_cyc);
            cfg_addr = 6'd3; cfg_wdata = 13'h1234;
            resetn = !((rst_cyc > 0) && (cyc == rst_cyc || cyc == rst_cyc + 1));
        end
        start = 1'b0; cfg_wr = 1'b0; resetn = 1'b1;
    endtask

    task automatic test_reset;
        int bad;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({busy, done, cfg_wr_err, loader_resetn, loader_clock, loader_load, loader_data} !== 8'b0001_0000) begin
            $display("FAIL reset_outputs: got %b want 00010000",
                     {busy, done, cfg_wr_err, loader_resetn, loader_clock, loader_load, loader_data}); n_bad++;
        end
        n_cmp++;
        bad = 0;
        for (int a = 0; a < 38; a++) begin
            cfg_addr = 6'(a); #1;
            if (cfg_rdata !== 13'h0403) bad++;
        end
        if (bad != 0) begin $display("FAIL reset_cfg_regs: %0d pads differ from 0403", bad); n_bad++; end
        n_cmp++;
        cfg_addr = 6'd40; #1;
        if (cfg_rdata !== 13'h0) begin $display("FAIL read_oor40: got %h want 0", cfg_rdata); n_bad++; end
        n_cmp++;
        b_cfg_addr = 3'd4; #1;
        if (b_cfg_rdata !== 4'h3) begin $display("FAIL reset_small_cfg: got %h want 3", b_cfg_rdata); n_bad++; end
        n_cmp++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_write;
        logic err;
        do_write(6'd38, 13'h0ABC, err);
        if (err !== 1'b1) begin $display("FAIL wr_oor38_err: got %b want 1", err); n_bad++; end
        n_cmp++;
        cfg_addr = 6'd38; #1;
        if (cfg_rdata !== 13'h0) begin $display("FAIL read_oor38: got %h want 0", cfg_rdata); n_bad++; end
        n_cmp++;
        do_write(6'd5, 13'h0ABC, err);
        if (err !== 1'b0) begin $display("FAIL wr_ok_err: got %b want 0", err); n_bad++; end
        n_cmp++;
        cfg_addr = 6'd5; #1;
        if (cfg_rdata !== 13'h0ABC) begin $display("FAIL wr_ok_readback: got %h want 0abc", cfg_rdata); n_bad++; end
        n_cmp++;
        do_write(6'd5, 13'h0403, err);
    endtask

    task automatic test_full_load;
        logic [12:0] dflt;
        int bad;
        dflt = 13'h0403;
        run_seq(0, 0, 0, 0);
        if (rst_first !== 1 || rst_last !== 4 || rst_cnt !== 4) begin
            $display("FAIL crst_window: got %0d..%0d (%0d) want 1..4 (4)", rst_first, rst_last, rst_cnt); n_bad++;
        end
        n_cmp++;
        if (nrise !== 247) begin $display("FAIL clock_rises: got %0d want 247", nrise); n_bad++; end
        n_cmp++;
        if (load_first !== 993 || load_last !== 994 || load_cnt !== 2) begin
            $display("FAIL load_window: got %0d..%0d (%0d) want 993..994 (2)", load_first, load_last, load_cnt); n_bad++;
        end
        n_cmp++;
        if (done_cyc !== 995 || done_cnt !== 1) begin
            $display("FAIL done_cycle: got %0d x%0d want 995 x1", done_cyc, done_cnt); n_bad++;
        end
        n_cmp++;
        if (busy_low !== 996 || busy_after !== 0) begin
            $display("FAIL busy_release: got %0d (re-busy %0d) want 996 (0)", busy_low, busy_after); n_bad++;
        end
        n_cmp++;
        bad = 0;
        for (int i = 0; i < 247; i++) begin
            if (cap0[i] !== dflt[12 - (i % 13)]) bad++;
            if (cap1[i] !== dflt[12 - (i % 13)]) bad++;
        end
        if (bad != 0) begin $display("FAIL default_stream: %0d bits differ", bad); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_data_map;
        logic err;
        int bad0, bad1;
        for (int a = 0; a < 38; a++)
            do_write(6'(a), (a == 18) ? 13'h1FFF : (a == 19) ? 13'h0001 : 13'h0, err);
        run_seq(0, 0, 0, 0);
        bad0 = 0; bad1 = 0;
        for (int i = 0; i < 247; i++) begin
            if (cap0[i] !== ((i < 13) ? 1'b1 : 1'b0)) bad0++;
            if (cap1[i] !== ((i == 246) ? 1'b1 : 1'b0)) bad1++;
        end
        if (bad0 != 0) begin $display("FAIL map_chain0: %0d bits differ", bad0); n_bad++; end
        n_cmp++;
        if (bad1 != 0) begin $display("FAIL map_chain1: %0d bits differ", bad1); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_odd_padding;
        logic pclk;
        int nr, dcyc, bad0, bad1;
        logic s0 [16];
        logic s1 [16];
        for (int a = 0; a < 5; a++) begin
            @(negedge clk);
            b_cfg_wr = 1'b1; b_cfg_addr = 3'(a); b_cfg_wdata = 4'hF;
        end
        @(negedge clk);
        b_cfg_wr = 1'b0; b_start = 1'b1;
        pclk = 1'b0; nr = 0; dcyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_loader_clock && !pclk) begin
                if (nr < 16) begin s0[nr] = b_loader_data[0]; s1[nr] = b_loader_data[1]; end
                nr++;
            end
            pclk = b_loader_clock;
            if (b_done && dcyc < 0) dcyc = cyc;
        end
        if (nr !== 12) begin $display("FAIL odd_rises: got %0d want 12", nr); n_bad++; end
        n_cmp++;
        if (dcyc !== 28) begin $display("FAIL odd_done_cycle: got %0d want 28", dcyc); n_bad++; end
        n_cmp++;
        bad0 = 0; bad1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (s0[i] !== 1'b1) bad0++;
            if (s1[i] !== ((i < 4) ? 1'b0 : 1'b1)) bad1++;
        end
        if (bad0 != 0) begin $display("FAIL odd_chain0: %0d bits differ", bad0); n_bad++; end
        n_cmp++;
        if (bad1 != 0) begin $display("FAIL odd_chain1: %0d bits differ", bad1); n_bad++; end
        n_cmp++;
        b_cfg_addr = 3'd6; #1;
        if (b_cfg_rdata !== 4'h0) begin $display("FAIL odd_read_oor: got %h want 0", b_cfg_rdata); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_busy_protect;
        run_seq(100, 200, 995, 0);
        if (err_cnt !== 1 || err_first !== 101) begin
            $display("FAIL busy_wr_err: got x%0d at %0d want x1 at 101", err_cnt, err_first); n_bad++;
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== 995) begin
            $display("FAIL busy_restart: got done x%0d at %0d want x1 at 995", done_cnt, done_cyc); n_bad++;
        end
        n_cmp++;
        if (busy_low !== 996 || busy_after !== 0) begin
            $display("FAIL done_start_ignored: got idle %0d re-busy %0d want 996 0", busy_low, busy_after); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        cfg_addr = 6'd3; #1;
        if (cfg_rdata !== 13'h0) begin $display("FAIL busy_pad3_kept: got %h want 0", cfg_rdata); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_mid_reset;
        run_seq(0, 0, 0, 500);
        if (snap !== 8'b0001_0000) begin $display("FAIL midrst_outputs: got %b want 00010000", snap); n_bad++; end
        n_cmp++;
        if (done_cnt !== 0) begin $display("FAIL midrst_no_done: got %0d want 0", done_cnt); n_bad++; end
        n_cmp++;
        @(negedge clk);
        cfg_addr = 6'd18; #1;
        if (cfg_rdata !== 13'h0403) begin $display("FAIL midrst_pad18: got %h want 0403", cfg_rdata); n_bad++; end
        n_cmp++;
        cfg_addr = 6'd19; #1;
        if (cfg_rdata !== 13'h0403) begin $display("FAIL midrst_pad19: got %h want 0403", cfg_rdata); n_bad++; end
        n_cmp++;
    endtask

    initial begin
        resetn = 1'b0; cfg_wr = 1'b0; start = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        b_cfg_wr = 1'b0; b_start = 1'b0; b_cfg_addr = '0; b_cfg_wdata = '0;
        test_reset();
        test_idle_write();
        test_full_load();
        test_data_map();
        test_odd_padding();
        test_busy_protect();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mprj_io_cfg_loader.md
Name: mprj_io_cfg_loader

Overview:
- Parametrised serial configuration loader for user-project I/O pad control cells, driven from the management SoC.
- Successor to the fixed two-chain `mprj_io_loader_*` signalling: pad count, config width, chain count and bit rate are parameters, and it holds its own config register file.
- Adds an explicit load strobe and done/busy handshakes.
- Software writes per-pad config words, pulses `start`; the block resets the chains, shifts all words out MSB-first on NUM_CHAINS parallel data lines, then strobes load.

Parameters:
- NUM_PADS, 38, number of user I/O pads configured.
- NUM_CHAINS, 2, number of parallel serial chains (1..4).
- CFG_BITS, 13, config bits per pad.
- CLK_DIV, 2, clk cycles per loader_clock half-period (>=1).
- DEFAULT_CFG, 13'h0403, reset value of every pad config register (width CFG_BITS).

Ports:
- clk  input  1  core clock
- resetn  input  1  synchronous active-low reset
- cfg_wr  input  1  write strobe for pad config register
- cfg_addr  input  $clog2(NUM_PADS)  pad index for write/read
- cfg_wdata  input  CFG_BITS  config word to write
- cfg_rdata  output  CFG_BITS  config word of pad cfg_addr (combinational)
- cfg_wr_err  output  1  one-cycle pulse: write rejected (busy or addr out of range)
- start  input  1  begin load sequence (level sampled each cycle)
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at end of sequence
- loader_resetn  output  1  chain reset, active low
- loader_clock  output  1  serial shift clock
- loader_load  output  1  parallel load strobe to pad cells
- loader_data  output  NUM_CHAINS  serial data, one bit per chain

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (resetn). All state is updated only on the rising edge of clk.
- Reset values: busy=0, done=0, cfg_wr_err=0, loader_resetn=1, loader_clock=0, loader_load=0, loader_data=0, all config regs=DEFAULT_CFG, FSM=IDLE.
- Reset asserted mid-sequence aborts the sequence: the next edge forces the reset values, and no done pulse is issued.
- Derived values:
  - PPC = ceil(NUM_PADS/NUM_CHAINS)
  - NBITS = PPC*CFG_BITS
  - bit period = 2*CLK_DIV cycles
- Chain mapping: chain c, slot k (k=0 shifted first) carries pad c*PPC + (PPC-1-k). Within a pad, bits are sent MSB first. Slots whose pad index is >= NUM_PADS shift 0.
- Config writes:
  - Accepted when cfg_wr=1, busy=0 and cfg_addr<NUM_PADS; the register updates on that edge.
  - Otherwise the register is unchanged and cfg_wr_err pulses one cycle.
  - cfg_rdata returns 0 for an out-of-range address.
  - Reads are always allowed.
- FSM states: IDLE, CRST, SHIFT, LOAD, DONE.
  - IDLE: start=1 -> CRST. busy goes to 1 on the next cycle. start while busy is ignored.
  - CRST: loader_resetn=0 for 2*CLK_DIV cycles -> SHIFT.
  - SHIFT: for each bit, loader_data is updated at the start of the period and held for 2*CLK_DIV cycles; loader_clock=0 for the first CLK_DIV cycles and 1 for the second CLK_DIV. After NBITS periods -> LOAD, with loader_clock=0 and loader_data=0.
  - LOAD: loader_load=1 for CLK_DIV cycles -> DONE.
  - DONE: done=1 and busy=1 for one cycle -> IDLE (busy=0 the next cycle).
- Timing relative to the start-sample edge (cycle 0):
  - CRST occupies cycles 1..2*CLK_DIV.
  - SHIFT occupies the next NBITS*2*CLK_DIV cycles.
  - LOAD occupies the next CLK_DIV cycles.
  - done is high in the following cycle.
- Counters: a bit counter of width $clog2(NBITS+1) and a divider counter of width $clog2(2*CLK_DIV). Both clear on entry to each state. There is no wrap beyond NBITS.
- Config regs are sampled live during SHIFT; they are write-locked while busy, so the sequence is consistent.
- start=1 in the same cycle as the DONE state is ignored; a new sequence needs start again in IDLE.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> all outputs at reset values; cfg_rdata for addr 0..37 = 13'h0403; addr 40 reads 0.
- Full load, defaults (38 pads, 2 chains, 13 bits, CLK_DIV=2), start pulsed at cycle 0 -> expected timing:
  - loader_resetn=0 in cycles 1–4.
  - 247 loader_clock rising edges.
  - loader_load=1 in cycles 993–994.
  - done=1 in cycle 995; busy=0 in cycle 996.
- Data mapping: write pad18=13'h1FFF, pad19=13'h0001, other pads 0; run a sequence -> on loader_clock rising edges:
  - loader_data[0]: the first 13 bits sampled are 1.
  - loader_data[1]: bits 0..233 are 0; bit 246 (last) is 1.
- Odd padding (NUM_PADS=5, NUM_CHAINS=2, CFG_BITS=4, CLK_DIV=1), all regs=4'hF -> expected stream:
  - PPC=3, so 12 bits per chain.
  - loader_data[1]: the first 4 bits are 0, the remaining 8 are 1.
  - loader_data[0]: all 12 bits are 1.
- Busy protection: cfg_wr to pad 3 during SHIFT -> cfg_wr_err pulses and pad 3 is unchanged. A second start during SHIFT -> no restart; exactly one done. A write with cfg_addr=38 in IDLE -> cfg_wr_err.
- Reset mid-operation: resetn=0 at cycle 500 of a sequence -> the next edge returns all outputs to reset values, done is never asserted, and config regs return to 13'h0403.
